vga_stream_timing: RTL and testbench

- Pixel-domain successor to the fixed 800x480 VGA controller.
- Generates fully parametrised HS/VS/BLANK timing and pulls 32-bit pixel words from a show-ahead async FIFO read port.
- Frames align using a start-of-frame (SOF) tag carried in each FIFO word. Underflow and misalignment are detected, counted and recovered by resynchronising at the next frame.
- Sits between the async FIFO (Wishbone/SDRAM reader on the write side) and video_if.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_sync_counter.sv | 51 +++++
 rtl/vga_stream_timing.sv | 171 +++++++++++++++++
 tb/tb_vga_stream_timing.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types, constants and helpers for the streaming VGA timing block.
package vga_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned RGB_W  = 24;
   localparam int unsigned ERR_W  = 16;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      ARMED    = 2'd1,
      RUN      = 2'd2
   } vga_state_e;

   localparam logic [RGB_W-1:0] BAR_WHITE   = 24'hFF_FF_FF;
   localparam logic [RGB_W-1:0] BAR_YELLOW  = 24'hFF_FF_00;
   localparam logic [RGB_W-1:0] BAR_CYAN    = 24'h00_FF_FF;
   localparam logic [RGB_W-1:0] BAR_GREEN   = 24'h00_FF_00;
   localparam logic [RGB_W-1:0] BAR_MAGENTA = 24'hFF_00_FF;
   localparam logic [RGB_W-1:0] BAR_RED     = 24'hFF_00_00;
   localparam logic [RGB_W-1:0] BAR_BLUE    = 24'h00_00_FF;
   localparam logic [RGB_W-1:0] BAR_BLACK   = 24'h00_00_00;

   // Total length of a line or frame: active + front porch + pulse + back porch.
   function automatic int unsigned timing_total(input int unsigned disp, input int unsigned fp,
                                                input int unsigned pulse, input int unsigned bp);
      return disp + fp + pulse + bp;
   endfunction

   // Colour of bar idx, left to right.
   function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return BAR_WHITE;
         3'd1:    return BAR_YELLOW;
         3'd2:    return BAR_CYAN;
         3'd3:    return BAR_GREEN;
         3'd4:    return BAR_MAGENTA;
         3'd5:    return BAR_RED;
         3'd6:    return BAR_BLUE;
         default: return BAR_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Free-running horizontal/vertical position counters with raw active/sync decode.
module vga_sync_counter
   import vga_pkg::*;
#(
   parameter int unsigned HDISP  = 800,
   parameter int unsigned HFP    = 40,
   parameter int unsigned HPULSE = 48,
   parameter int unsigned HBP    = 40,
   parameter int unsigned VDISP  = 480,
   parameter int unsigned VFP    = 13,
   parameter int unsigned VPULSE = 3,
   parameter int unsigned VBP    = 29,
   localparam int unsigned HW = $clog2(timing_total(HDISP, HFP, HPULSE, HBP)),
   localparam int unsigned VW = $clog2(timing_total(VDISP, VFP, VPULSE, VBP))
) (
   input  logic          pixel_clk,
   input  logic          pixel_rst_n,
   output logic [HW-1:0] hcnt,
   output logic [VW-1:0] vcnt,
   output logic          active_c,
   output logic          hs_pulse_c,
   output logic          vs_pulse_c
);

   localparam logic [HW-1:0] H_LAST      = HW'(timing_total(HDISP, HFP, HPULSE, HBP) - 1);
   localparam logic [HW-1:0] H_ACT_END   = HW'(HDISP);
   localparam logic [HW-1:0] H_PULSE_BEG = HW'(HDISP + HFP);
   localparam logic [HW-1:0] H_PULSE_END = HW'(HDISP + HFP + HPULSE);
   localparam logic [VW-1:0] V_LAST      = VW'(timing_total(VDISP, VFP, VPULSE, VBP) - 1);
   localparam logic [VW-1:0] V_ACT_END   = VW'(VDISP);
   localparam logic [VW-1:0] V_PULSE_BEG = VW'(VDISP + VFP);
   localparam logic [VW-1:0] V_PULSE_END = VW'(VDISP + VFP + VPULSE);

   // Pixel position: hcnt wraps into a vcnt step, vcnt wraps at end of frame.
   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == H_LAST) begin
         hcnt <= '0;
         vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
      end else begin
         hcnt <= hcnt + HW'(1);
      end
   end

   assign active_c   = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
   assign hs_pulse_c = (hcnt >= H_PULSE_BEG) && (hcnt < H_PULSE_END);
   assign vs_pulse_c = (vcnt >= V_PULSE_BEG) && (vcnt < V_PULSE_END);

endmodule

// File: rtl/vga_stream_timing.sv
// VGA timing generator fed by a show-ahead FIFO of SOF-tagged RGB words.
// Optional colour-bar test pattern enabled by defining VGA_TEST_PATTERN_EN.
module vga_stream_timing
   import vga_pkg::*;
#(
   parameter int unsigned HDISP   = 800,
   parameter int unsigned VDISP   = 480,
   parameter int unsigned HFP     = 40,
   parameter int unsigned HPULSE  = 48,
   parameter int unsigned HBP     = 40,
   parameter int unsigned VFP     = 13,
   parameter int unsigned VPULSE  = 3,
   parameter int unsigned VBP     = 29,
   parameter logic        HS_POL  = 1'b0,
   parameter logic        VS_POL  = 1'b0,
   parameter int unsigned SOF_BIT = 24
) (
   input  logic              pixel_clk,
   input  logic              pixel_rst_n,
   input  logic [WORD_W-1:0] fifo_rdata,
   input  logic              fifo_rempty,
   output logic              fifo_read,
`ifdef VGA_TEST_PATTERN_EN
   input  logic              test_mode,
`endif
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_blank,
   output logic [RGB_W-1:0]  vga_rgb,
   output logic              frame_start,
   output logic              locked,
   input  logic              err_clr,
   output logic              err_sticky,
   output logic [ERR_W-1:0]  err_cnt
);

   localparam int unsigned HW = $clog2(timing_total(HDISP, HFP, HPULSE, HBP));
   localparam int unsigned VW = $clog2(timing_total(VDISP, VFP, VPULSE, VBP));

   logic [HW-1:0]    hcnt;
   logic [VW-1:0]    vcnt;
   logic             active_c;
   logic             hs_pulse_c;
   logic             vs_pulse_c;
   logic             origin_c;
   logic             sof_c;
   logic             consume_c;
   logic             pop_c;
   logic             err_c;
   logic [RGB_W-1:0] rgb_c;
   logic             unused_word_bits_c;
   vga_state_e       state;
   vga_state_e       state_nxt;

   vga_sync_counter #(
      .HDISP  (HDISP),
      .HFP    (HFP),
      .HPULSE (HPULSE),
      .HBP    (HBP),
      .VDISP  (VDISP),
      .VFP    (VFP),
      .VPULSE (VPULSE),
      .VBP    (VBP)
   ) u_sync (
      .pixel_clk   (pixel_clk),
      .pixel_rst_n (pixel_rst_n),
      .hcnt        (hcnt),
      .vcnt        (vcnt),
      .active_c    (active_c),
      .hs_pulse_c  (hs_pulse_c),
      .vs_pulse_c  (vs_pulse_c)
   );

   assign origin_c           = (hcnt == '0) && (vcnt == '0);
   assign sof_c              = fifo_rdata[SOF_BIT];
   assign unused_word_bits_c = ^fifo_rdata;

`ifdef VGA_TEST_PATTERN_EN
   localparam int unsigned BAR_W = (HDISP / 8 > 0) ? HDISP / 8 : 1;
   logic [HW-1:0] bar_q_c;
   logic [2:0]    bar_idx_c;

   // Bar index from column, clamped to the last bar for non-multiple-of-8 widths.
   always_comb begin
      bar_q_c   = hcnt / HW'(BAR_W);
      bar_idx_c = (bar_q_c > HW'(7)) ? 3'd7 : 3'(bar_q_c);
   end
`endif

   // State register.
   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) state <= WAIT_SOF;
      else              state <= state_nxt;
   end

   // Next state: hunt for SOF, wait for frame origin, then stream until an error.
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_SOF: if (!fifo_rempty && sof_c) state_nxt = ARMED;
         ARMED:    if (origin_c) state_nxt = err_c ? WAIT_SOF : RUN;
         RUN:      if (err_c) state_nxt = WAIT_SOF;
         default:  state_nxt = WAIT_SOF;
      endcase
`ifdef VGA_TEST_PATTERN_EN
      if (test_mode) state_nxt = WAIT_SOF;
`endif
   end

   // Per-cycle FIFO pop, pixel colour and error decision.
   always_comb begin
      pop_c     = 1'b0;
      err_c     = 1'b0;
      rgb_c     = '0;
      consume_c = active_c && ((state == RUN) || ((state == ARMED) && origin_c));
      if (state == WAIT_SOF) begin
         pop_c = !fifo_rempty && !sof_c;
      end else if (consume_c) begin
         // SOF must be present exactly at the origin pixel and nowhere else.
         if (fifo_rempty || (sof_c != origin_c)) begin
            err_c = 1'b1;
         end else begin
            pop_c = 1'b1;
            rgb_c = fifo_rdata[RGB_W-1:0];
         end
      end
`ifdef VGA_TEST_PATTERN_EN
      if (test_mode) begin
         pop_c = 1'b0;
         err_c = 1'b0;
         rgb_c = active_c ? bar_colour(bar_idx_c) : '0;
      end
`endif
   end

   // Pop must not reach the FIFO while held in reset.
   assign fifo_read = pop_c & pixel_rst_n;
   assign locked    = (state == RUN);

   // Video output registers: one cycle behind the counters.
   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         vga_hs      <= ~HS_POL;
         vga_vs      <= ~VS_POL;
         vga_blank   <= 1'b0;
         vga_rgb     <= '0;
         frame_start <= 1'b0;
      end else begin
         vga_hs      <= hs_pulse_c ? HS_POL : ~HS_POL;
         vga_vs      <= vs_pulse_c ? VS_POL : ~VS_POL;
         vga_blank   <= active_c;
         vga_rgb     <= rgb_c;
         frame_start <= origin_c;
      end
   end

   // Error flag and saturating counter; clear has priority over a new error.
   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         err_sticky <= 1'b0;
         err_cnt    <= '0;
      end else if (err_clr) begin
         err_sticky <= 1'b0;
         err_cnt    <= '0;
      end else if (err_c) begin
         err_sticky <= 1'b1;
         if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
      end
   end

endmodule

// File: tb/tb_vga_stream_timing.sv
// Self-checking bench: queue-backed FIFO and a frame-level reference model.
module tb_vga_stream_timing;

   localparam int HDISP  = 8;
   localparam int VDISP  = 4;
   localparam int HFP    = 2;
   localparam int HPULSE = 2;
   localparam int HBP    = 2;
   localparam int VFP    = 1;
   localparam int VPULSE = 1;
   localparam int VBP    = 1;
   localparam int H_TOT  = HDISP + HFP + HPULSE + HBP;
   localparam int V_TOT  = VDISP + VFP + VPULSE + VBP;
   localparam int F_TOT  = H_TOT * V_TOT;
   localparam int M_SEEK = 0;
   localparam int M_ARM  = 1;
   localparam int M_LOCK = 2;

   logic        pixel_clk = 1'b0;
   logic        pixel_rst_n;
   logic [31:0] fifo_rdata;
   logic        fifo_rempty;
   logic        fifo_read;
   logic        vga_hs;
   logic        vga_vs;
   logic        vga_blank;
   logic [23:0] vga_rgb;
   logic        frame_start;
   logic        locked;
   logic        err_clr;
   logic        err_sticky;
   logic [15:0] err_cnt;

   vga_stream_timing #(
      .HDISP (HDISP), .VDISP (VDISP), .HFP (HFP), .HPULSE (HPULSE), .HBP (HBP),
      .VFP (VFP), .VPULSE (VPULSE), .VBP (VBP),
      .HS_POL (1'b0), .VS_POL (1'b0), .SOF_BIT (24)
   ) dut (
      .pixel_clk   (pixel_clk),
      .pixel_rst_n (pixel_rst_n),
      .fifo_rdata  (fifo_rdata),
      .fifo_rempty (fifo_rempty),
      .fifo_read   (fifo_read),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_blank   (vga_blank),
      .vga_rgb     (vga_rgb),
      .frame_start (frame_start),
      .locked      (locked),
      .err_clr     (err_clr),
      .err_sticky  (err_sticky),
      .err_cnt     (err_cnt)
   );

   always #5 pixel_clk = ~pixel_clk;

   logic [31:0] fq[$];
   int          pos;
   int          m_mode;
   bit          m_sticky;
   logic [15:0] m_cnt;
   logic        e_hs, e_vs, e_blank, e_fs;
   logic [23:0] e_rgb;
   bit          clr_on_err;
   int          n_checks;
   int          n_fail;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at pos %0d: got %h expected %h", tag, pos, got, exp);
      end
   endtask

   task automatic check_outputs();
      check_eq("vga_hs",      32'(vga_hs),      32'(e_hs));
      check_eq("vga_vs",      32'(vga_vs),      32'(e_vs));
      check_eq("vga_blank",   32'(vga_blank),   32'(e_blank));
      check_eq("vga_rgb",     32'(vga_rgb),     32'(e_rgb));
      check_eq("frame_start", 32'(frame_start), 32'(e_fs));
      check_eq("locked",      32'(locked),      32'(m_mode == M_LOCK));
      check_eq("err_sticky",  32'(err_sticky),  32'(m_sticky));
      check_eq("err_cnt",     32'(err_cnt),     32'(m_cnt));
   endtask

   task automatic model_reset();
      pos      = 0;
      m_mode   = M_SEEK;
      m_sticky = 1'b0;
      m_cnt    = 16'h0;
      e_hs     = 1'b1;
      e_vs     = 1'b1;
      e_blank  = 1'b0;
      e_rgb    = 24'h0;
      e_fs     = 1'b0;
   endtask

   // Show-ahead FIFO head; data is garbage while empty.
   task automatic drive_fifo();
      fifo_rempty = (fq.size() == 0);
      fifo_rdata  = (fq.size() == 0) ? $urandom : fq[0];
   endtask

   // Push n words; the word at index sof_idx (if in range) carries the SOF tag.
   task automatic push_words(input int n, input int sof_idx);
      for (int i = 0; i < n; i++)
         fq.push_back({7'($urandom), (i == sof_idx), 24'($urandom)});
      drive_fifo();
   endtask

   // One pixel clock: predict the cycle from the stream rules, then compare.
   task automatic step();
      int          h, v;
      bit          act, org, empty, sof, consume, err, clr;
      logic [31:0] head;
      logic [23:0] rgb;
      logic        exp_pop, dut_pop;
      drive_fifo();
      @(negedge pixel_clk);
      h       = pos % H_TOT;
      v       = pos / H_TOT;
      act     = (h < HDISP) && (v < VDISP);
      org     = (pos == 0);
      empty   = (fq.size() == 0);
      head    = empty ? 32'h0 : fq[0];
      sof     = head[24];
      exp_pop = 1'b0;
      err     = 1'b0;
      rgb     = 24'h0;
      consume = 1'b0;
      if (m_mode == M_SEEK) exp_pop = !empty && !sof;
      else                  consume = act && (m_mode == M_LOCK || org);
      if (consume) begin
         if (empty)            err = 1'b1;  // underflow
         else if (org && !sof) err = 1'b1;  // late frame
         else if (!org && sof) err = 1'b1;  // early frame, word kept
         else begin
            exp_pop = 1'b1;
            rgb     = head[23:0];
         end
      end
      if (clr_on_err && err) err_clr = 1'b1;
      clr = err_clr;
      check_eq("fifo_read", 32'(fifo_read), 32'(exp_pop));
      dut_pop = fifo_read;
      @(posedge pixel_clk);
      if (dut_pop && fq.size() > 0) fq.delete(0);
      e_hs    = (h >= HDISP + HFP && h < HDISP + HFP + HPULSE) ? 1'b0 : 1'b1;
      e_vs    = (v >= VDISP + VFP && v < VDISP + VFP + VPULSE) ? 1'b0 : 1'b1;
      e_blank = act;
      e_rgb   = rgb;
      e_fs    = org;
      if (clr) begin
         m_sticky = 1'b0;
         m_cnt    = 16'h0;
      end else if (err) begin
         m_sticky = 1'b1;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (m_mode == M_SEEK) begin
         if (!empty && sof) m_mode = M_ARM;
      end else if (consume) begin
         m_mode = err ? M_SEEK : M_LOCK;
      end
      pos = (pos + 1) % F_TOT;
      #1;
      if (clr_on_err && err) err_clr = 1'b0;
      check_outputs();
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Asynchronous reset pulse starting mid-cycle; outputs must drop at once.
   task automatic reset_pulse();
      #2;
      pixel_rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      check_eq("rst_fifo_read", 32'(fifo_read), 32'h0);
      @(posedge pixel_clk);
      #1;
      check_outputs();
      @(posedge pixel_clk);
      #3;
      pixel_rst_n = 1'b1;
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      clr_on_err  = 1'b0;
      err_clr     = 1'b0;
      pixel_rst_n = 1'b0;
      fifo_rdata  = 32'h0;
      fifo_rempty = 1'b1;
      model_reset();
      repeat (2) @(posedge pixel_clk);
      #1;
      check_outputs();
      check_eq("rst_fifo_read", 32'(fifo_read), 32'h0);
      @(posedge pixel_clk);
      #3;
      pixel_rst_n = 1'b1;

      // Free-running timing with an empty FIFO.
      run_cycles(2 * F_TOT);

      // Three stray words, then two good frames.
      push_words(3, -1);
      push_words(32, 0);
      push_words(32, 0);
      run_cycles(3 * F_TOT);

      // Clean error state, then a frame that runs dry at pixel (5,2), then a good frame.
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      push_words(32, 0);
      push_words(21, 0);
      push_words(32, 0);
      run_cycles(4 * F_TOT);

      // SOF appearing on word 20 restarts the frame from that word.
      push_words(32, 0);
      push_words(20, 0);
      push_words(32, 0);
      run_cycles(4 * F_TOT);

      // Counter saturation.
      force dut.err_cnt = 16'hFFFF;
      #2;
      release dut.err_cnt;
      m_cnt = 16'hFFFF;
      push_words(32, 0);
      push_words(10, 0);
      run_cycles(3 * F_TOT);

      // Clear coinciding with an error.
      clr_on_err = 1'b1;
      push_words(32, 0);
      push_words(5, 0);
      run_cycles(3 * F_TOT);
      clr_on_err = 1'b0;

      // Reset in the middle of a line with stray words pending.
      push_words(32, 0);
      run_cycles(F_TOT + 3);
      push_words(4, -1);
      reset_pulse();
      push_words(32, 0);
      run_cycles(3 * F_TOT);

      // Randomised frames: good, truncated or with an early SOF.
      for (int k = 0; k < 8; k++) begin
         case ($urandom_range(0, 2))
            0:       push_words(32, 0);
            1:       push_words(int'($urandom_range(1, 31)), 0);
            default: begin
               push_words(int'($urandom_range(1, 31)), 0);
               push_words(32, 0);
            end
         endcase
         if ($urandom_range(0, 3) == 0) begin
            err_clr = 1'b1;
            step();
            err_clr = 1'b0;
         end
         run_cycles(2 * F_TOT + int'($urandom_range(0, 20)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
